// File: rtl/ecc_scrubber_if.sv
// ecc_scrubber_if: scrub bus between the scrubber (slave) and the cache array plus control (master)
// Carries start/hold control, the array read/write ports, status, error reports and counters.
interface ecc_scrubber_if #(parameter int ADDR_W = 9);
  logic start, hold, rd_en, wr_dwe, wr_pwe, busy, done, err_valid;
  logic [ADDR_W-1:0] scrub_addr, err_addr;
  logic [31:0] rd_data, wr_din;
  logic [6:0] rd_parity, wr_pin;
  logic [1:0] err_type;
  logic [15:0] corr_count, uncorr_count;
  modport slave (
    input start, hold, rd_data, rd_parity,
    output scrub_addr, rd_en, wr_dwe, wr_pwe, wr_din, wr_pin, busy, done,
    err_valid, err_addr, err_type, corr_count, uncorr_count
  );
  modport master (
    output start, hold, rd_data, rd_parity,
    input scrub_addr, rd_en, wr_dwe, wr_pwe, wr_din, wr_pin, busy, done,
    err_valid, err_addr, err_type, corr_count, uncorr_count
  );
endinterface

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: walks DEPTH words, SEC-DED checks each and writes back single-bit corrections
// Ports: clk, rst (sync, active high); bus = ecc_scrubber_if.slave (start/hold in, array read/write,
// busy/done status, one-cycle error report, saturating per-pass corrected/uncorrectable counters).
module ecc_scrubber #(
  parameter int DEPTH = 512,
  parameter int ADDR_W = 9
) (
  input logic clk,
  input logic rst,
  ecc_scrubber_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, NEXT} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_din, w_fix;
  logic [6:0] r_pin, w_enc, w_pfix;
  logic [15:0] r_corr, r_uncorr;
  logic [5:0] w_syn;
  logic [1:0] w_type;
  logic r_done, w_odd, w_last;
  // Hamming check bits over positions 1..38 (data skips powers of two), p[6] = overall parity.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] p;
    int k;
    p = '0;
    k = 0;
    for (int pos = 1; pos < 39; pos++)
      if ((pos & (pos - 1)) != 0) begin
        for (int i = 0; i < 6; i++)
          if ((pos & (1 << i)) != 0) p[i] = p[i] ^ d[k[4:0]];
        k++;
      end
    p[6] = ^{d, p[5:0]};
    return p;
  endfunction
  // Mask with the data bit living at codeword position s; zero for check-bit or out-of-range positions.
  function automatic logic [31:0] flip(input logic [5:0] s);
    logic [31:0] m;
    int k;
    m = '0;
    k = 0;
    for (int pos = 1; pos < 39; pos++)
      if ((pos & (pos - 1)) != 0) begin
        if (pos == int'(s)) m[k[4:0]] = 1'b1;
        k++;
      end
    return m;
  endfunction
  always_comb begin
    w_enc = enc(bus.rd_data);
    w_syn = w_enc[5:0] ^ bus.rd_parity[5:0];
    w_odd = ^{bus.rd_data, bus.rd_parity};
    w_type = !w_odd ? (w_syn == '0 ? 2'd0 : 2'd2) : (w_syn > 6'd38 ? 2'd2 : 2'd1);
    w_fix = bus.rd_data ^ flip(w_syn);
    w_pfix = enc(w_fix);
    w_last = r_addr == ADDR_W'(DEPTH - 1);
    w_next = r_state;
    case (r_state)
      IDLE: w_next = bus.start ? READ : IDLE;
      READ: w_next = bus.hold ? READ : CHECK;
      CHECK: w_next = w_type == 2'd1 ? WRITE : NEXT;
      WRITE: w_next = bus.hold ? WRITE : NEXT;
      NEXT: w_next = w_last ? IDLE : READ;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_din <= '0;
      r_pin <= '0;
      r_corr <= '0;
      r_uncorr <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == NEXT && w_last;
      if (r_state == IDLE && bus.start) begin
        r_addr <= '0;
        r_corr <= '0;
        r_uncorr <= '0;
      end
      if (r_state == NEXT && !w_last) r_addr <= r_addr + 1'b1;
      if (r_state == CHECK) begin
        r_din <= w_fix;
        r_pin <= w_pfix;
        if (w_type == 2'd1 && r_corr != '1) r_corr <= r_corr + 1'b1;
        if (w_type == 2'd2 && r_uncorr != '1) r_uncorr <= r_uncorr + 1'b1;
      end
    end
  end
  assign bus.scrub_addr = r_addr;
  assign bus.rd_en = r_state == READ && !bus.hold;
  assign bus.wr_dwe = r_state == WRITE && !bus.hold;
  assign bus.wr_pwe = r_state == WRITE && !bus.hold;
  assign bus.wr_din = r_din;
  assign bus.wr_pin = r_pin;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_done;
  assign bus.err_valid = r_state == CHECK && w_type != 2'd0;
  assign bus.err_addr = bus.err_valid ? r_addr : '0;
  assign bus.err_type = bus.err_valid ? w_type : 2'd0;
  assign bus.corr_count = r_corr;
  assign bus.uncorr_count = r_uncorr;
endmodule
